// File: rtl/vertex_batch_ctrl.sv
// Groups incoming X/Y/Z vertices into 4-column homogeneous matrices for the
// transform multiplier. A flush closes a partial batch early.
module vertex_batch_ctrl #(
  parameter int unsigned    W     = 16,
  parameter logic [W-1:0]   W_ONE = W'(32'h0020)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vin_valid,
  output logic              vin_ready,
  input  logic [W-1:0]      vin_x,
  input  logic [W-1:0]      vin_y,
  input  logic [W-1:0]      vin_z,
  input  logic              flush,
  output logic              mtx_valid,
  input  logic              mtx_ready,
  output logic [16*W-1:0]   mtx_data,
  output logic [3:0]        mtx_mask,
  output logic [15:0]       batch_cnt
);

  typedef enum logic {FILL, HOLD} state_e;

  state_e         state_q, state_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [2:0]     cnt_inc;
  logic [W-1:0]   x_q [4];
  logic [W-1:0]   y_q [4];
  logic [W-1:0]   z_q [4];
  logic [W-1:0]   x_d [4];
  logic [W-1:0]   y_d [4];
  logic [W-1:0]   z_d [4];
  logic [3:0]     mask_q, mask_d;
  logic [15:0]    batch_cnt_q, batch_cnt_d;
  logic           accept;

  assign accept    = (state_q == FILL) && vin_valid;
  assign cnt_inc   = cnt_q + {2'b00, accept};
  assign vin_ready = (state_q == FILL);
  assign mtx_valid = (state_q == HOLD);
  assign mtx_mask  = mask_q;
  assign batch_cnt = batch_cnt_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    mask_d      = mask_q;
    batch_cnt_d = batch_cnt_q;
    case (state_q)
      FILL: begin
        if (accept) begin
          x_d[cnt_q[1:0]] = vin_x;
          y_d[cnt_q[1:0]] = vin_y;
          z_d[cnt_q[1:0]] = vin_z;
          cnt_d           = cnt_inc;
        end
        if (accept && cnt_q == 3'd3) begin
          state_d = HOLD;
          mask_d  = '1;
        end else if (flush && cnt_inc != 3'd0) begin
          // cnt_inc is at most 3 here, so the thermometer mask fits in 4 bits
          state_d = HOLD;
          mask_d  = 4'((5'd1 << cnt_inc) - 5'd1);
        end
      end
      HOLD: begin
        if (mtx_ready) begin
          state_d     = FILL;
          cnt_d       = '0;
          x_d         = '{default: '0};
          y_d         = '{default: '0};
          z_d         = '{default: '0};
          mask_d      = '0;
          batch_cnt_d = batch_cnt_q + 16'd1;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    mtx_data = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      mtx_data[16*W-1-4*W*k -: 4*W] = {x_q[k], y_q[k], z_q[k], mask_q[k] ? W_ONE : '0};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      x_q         <= '{default: '0};
      y_q         <= '{default: '0};
      z_q         <= '{default: '0};
      mask_q      <= '0;
      batch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      mask_q      <= mask_d;
      batch_cnt_q <= batch_cnt_d;
    end
  end

endmodule

// File: tb/tb_vertex_batch_ctrl.sv
// Directed vector table, hand-written stall/wrap sequences and a randomized
// stream checked against a reference model for vertex_batch_ctrl.
module tb_vertex_batch_ctrl;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          vin_valid;
  logic          vin_ready;
  logic [15:0]   vin_x, vin_y, vin_z;
  logic          flush;
  logic          mtx_valid;
  logic          mtx_ready;
  logic [255:0]  mtx_data;
  logic [3:0]    mtx_mask;
  logic [15:0]   batch_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vertex_batch_ctrl #(.W(16), .W_ONE(16'h0020)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vin_valid (vin_valid),
    .vin_ready (vin_ready),
    .vin_x     (vin_x),
    .vin_y     (vin_y),
    .vin_z     (vin_z),
    .flush     (flush),
    .mtx_valid (mtx_valid),
    .mtx_ready (mtx_ready),
    .mtx_data  (mtx_data),
    .mtx_mask  (mtx_mask),
    .batch_cnt (batch_cnt)
  );

  typedef struct {
    logic         rst_n, vld, fl, mrdy;
    logic [15:0]  x, y, z;
    logic         e_rdy, e_vld;
    logic [3:0]   e_mask;
    logic [15:0]  e_bc;
    logic         chk_d;
    logic [255:0] e_data;
  } vec_t;

  function automatic logic [63:0] col(input logic [15:0] x, y, z);
    return {x, y, z, 16'h0020};
  endfunction

  function automatic vec_t v(input logic r, vl, input logic [15:0] x, y, z,
                             input logic fl, mr, er, ev, input logic [3:0] em,
                             input logic [15:0] eb, input logic cd, input logic [255:0] ed);
    vec_t t;
    t.rst_n = r; t.vld = vl; t.x = x; t.y = y; t.z = z; t.fl = fl; t.mrdy = mr;
    t.e_rdy = er; t.e_vld = ev; t.e_mask = em; t.e_bc = eb; t.chk_d = cd; t.e_data = ed;
    return t;
  endfunction

  task automatic chk(input string name, input logic [299:0] act, input logic [299:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, vl, input logic [15:0] x, y, z, input logic fl, mr);
    rst_n = r; vin_valid = vl; vin_x = x; vin_y = y; vin_z = z; flush = fl; mtx_ready = mr;
    @(posedge clk);
    #1;
  endtask

  vec_t tab[$];

  logic [15:0]  mx [4];
  logic [15:0]  my [4];
  logic [15:0]  mz [4];
  int           m_cnt;
  logic         m_hold;
  logic [3:0]   m_mask;
  logic [15:0]  m_bc;
  logic [255:0] m_data;

  initial begin
    rst_n = 1'b0; vin_valid = 1'b0; vin_x = '0; vin_y = '0; vin_z = '0;
    flush = 1'b0; mtx_ready = 1'b0;
    @(posedge clk);
    #1;

    // reset
    tab.push_back(v(0,0,16'h0,16'h0,16'h0,0,0, 1,0,4'h0,16'd0, 0,'0));
    // full batch with immediate handoff
    tab.push_back(v(1,1,16'd1,16'd2,16'd3,0,1, 1,0,4'h0,16'd0, 0,'0));
    tab.push_back(v(1,1,16'd4,16'd5,16'd6,0,1, 1,0,4'h0,16'd0, 0,'0));
    tab.push_back(v(1,1,16'd7,16'd8,16'd9,0,1, 1,0,4'h0,16'd0, 0,'0));
    tab.push_back(v(1,1,16'hFFFF,16'hFFFE,16'hFFFD,0,1, 0,1,4'hF,16'd0, 1,
      {col(16'd1,16'd2,16'd3), col(16'd4,16'd5,16'd6), col(16'd7,16'd8,16'd9),
       col(16'hFFFF,16'hFFFE,16'hFFFD)}));
    tab.push_back(v(1,0,16'h0,16'h0,16'h0,0,1, 1,0,4'h0,16'd1, 0,'0));
    tab.push_back(v(1,0,16'h0,16'h0,16'h0,0,1, 1,0,4'h0,16'd1, 0,'0));
    // two vertices then flush without accept
    tab.push_back(v(1,1,16'h000A,16'h0014,16'h001E,0,0, 1,0,4'h0,16'd1, 0,'0));
    tab.push_back(v(1,1,16'hFFFB,16'h0000,16'h0007,0,0, 1,0,4'h0,16'd1, 0,'0));
    tab.push_back(v(1,0,16'h0,16'h0,16'h0,1,0, 0,1,4'h3,16'd1, 1,
      {col(16'h000A,16'h0014,16'h001E), col(16'hFFFB,16'h0000,16'h0007), 128'h0}));
    tab.push_back(v(1,0,16'h0,16'h0,16'h0,0,1, 1,0,4'h0,16'd2, 0,'0));
    // flush concurrent with third accept, then flush and vin_valid during HOLD
    tab.push_back(v(1,1,16'h0100,16'h0200,16'h0300,0,0, 1,0,4'h0,16'd2, 0,'0));
    tab.push_back(v(1,1,16'h8000,16'h7FFF,16'h0001,0,0, 1,0,4'h0,16'd2, 0,'0));
    tab.push_back(v(1,1,16'h1234,16'hABCD,16'hFFFF,1,0, 0,1,4'h7,16'd2, 1,
      {col(16'h0100,16'h0200,16'h0300), col(16'h8000,16'h7FFF,16'h0001),
       col(16'h1234,16'hABCD,16'hFFFF), 64'h0}));
    tab.push_back(v(1,1,16'hDEAD,16'hBEEF,16'hCAFE,1,0, 0,1,4'h7,16'd2, 1,
      {col(16'h0100,16'h0200,16'h0300), col(16'h8000,16'h7FFF,16'h0001),
       col(16'h1234,16'hABCD,16'hFFFF), 64'h0}));
    tab.push_back(v(1,0,16'h0,16'h0,16'h0,1,1, 1,0,4'h0,16'd3, 0,'0));
    // flush with empty batch is ignored
    tab.push_back(v(1,0,16'h0,16'h0,16'h0,1,1, 1,0,4'h0,16'd3, 0,'0));
    tab.push_back(v(1,0,16'h0,16'h0,16'h0,1,0, 1,0,4'h0,16'd3, 0,'0));
    // single vertex + flush: slots from the previous batch must be gone
    tab.push_back(v(1,1,16'h0005,16'h0005,16'h0005,1,0, 0,1,4'h1,16'd3, 1,
      {col(16'h0005,16'h0005,16'h0005), 192'h0}));
    tab.push_back(v(1,0,16'h0,16'h0,16'h0,0,1, 1,0,4'h0,16'd4, 0,'0));
    // reset while holding discards the batch
    tab.push_back(v(1,1,16'h0011,16'h0012,16'h0013,0,0, 1,0,4'h0,16'd4, 0,'0));
    tab.push_back(v(1,1,16'h0021,16'h0022,16'h0023,0,0, 1,0,4'h0,16'd4, 0,'0));
    tab.push_back(v(1,1,16'h0031,16'h0032,16'h0033,0,0, 1,0,4'h0,16'd4, 0,'0));
    tab.push_back(v(1,1,16'h0041,16'h0042,16'h0043,0,0, 0,1,4'hF,16'd4, 0,'0));
    tab.push_back(v(0,0,16'h0,16'h0,16'h0,0,1, 1,0,4'h0,16'd0, 0,'0));
    tab.push_back(v(1,1,16'h0051,16'h0052,16'h0053,0,0, 1,0,4'h0,16'd0, 0,'0));
    tab.push_back(v(1,1,16'h0061,16'h0062,16'h0063,0,0, 1,0,4'h0,16'd0, 0,'0));
    tab.push_back(v(1,1,16'h0071,16'h0072,16'h0073,0,0, 1,0,4'h0,16'd0, 0,'0));
    tab.push_back(v(1,1,16'h0081,16'h0082,16'h0083,0,0, 0,1,4'hF,16'd0, 1,
      {col(16'h0051,16'h0052,16'h0053), col(16'h0061,16'h0062,16'h0063),
       col(16'h0071,16'h0072,16'h0073), col(16'h0081,16'h0082,16'h0083)}));
    tab.push_back(v(1,0,16'h0,16'h0,16'h0,0,1, 1,0,4'h0,16'd1, 0,'0));

    foreach (tab[i]) begin
      step(tab[i].rst_n, tab[i].vld, tab[i].x, tab[i].y, tab[i].z, tab[i].fl, tab[i].mrdy);
      chk($sformatf("row%0d_ctrl", i),
          300'({vin_ready, mtx_valid, tab[i].e_vld ? mtx_mask : 4'h0, batch_cnt}),
          300'({tab[i].e_rdy, tab[i].e_vld, tab[i].e_mask, tab[i].e_bc}));
      if (tab[i].chk_d)
        chk($sformatf("row%0d_data", i), 300'(mtx_data), 300'(tab[i].e_data));
    end

    // backpressure: hold for 10 cycles, data stable, then a single handoff
    step(1,1,16'h0101,16'h0102,16'h0103,0,0);
    step(1,1,16'h0201,16'h0202,16'h0203,0,0);
    step(1,1,16'h0301,16'h0302,16'h0303,0,0);
    step(1,1,16'h0401,16'h0402,16'h0403,0,0);
    for (int i = 0; i < 10; i++) begin
      step(1,1,16'hEEEE,16'hEEEE,16'hEEEE,0,0);
      chk($sformatf("stall%0d", i),
          300'({vin_ready, mtx_valid, mtx_mask, batch_cnt, mtx_data}),
          300'({1'b0, 1'b1, 4'hF, 16'd1,
                col(16'h0101,16'h0102,16'h0103), col(16'h0201,16'h0202,16'h0203),
                col(16'h0301,16'h0302,16'h0303), col(16'h0401,16'h0402,16'h0403)}));
    end
    step(1,0,16'h0,16'h0,16'h0,0,1);
    chk("stall_release", 300'({vin_ready, mtx_valid, batch_cnt}), 300'({1'b1, 1'b0, 16'd2}));
    step(1,0,16'h0,16'h0,16'h0,0,1);
    chk("stall_single", 300'({vin_ready, mtx_valid, batch_cnt}), 300'({1'b1, 1'b0, 16'd2}));

    // randomized stream against a reference model
    step(0,0,16'h0,16'h0,16'h0,0,0);
    m_cnt = 0; m_hold = 1'b0; m_mask = '0; m_bc = '0;
    for (int k = 0; k < 4; k++) begin mx[k] = '0; my[k] = '0; mz[k] = '0; end
    begin
      int           accepted;
      int           cyc;
      logic         have;
      logic [15:0]  cx, cy, cz;
      accepted = 0; cyc = 0; have = 1'b0; cx = '0; cy = '0; cz = '0;
      while (accepted < 10000 && cyc < 60000) begin
        if (!have) begin
          cx = 16'($urandom); cy = 16'($urandom); cz = 16'($urandom);
          have = 1'b1;
        end
        rst_n     = 1'b1;
        vin_valid = ($urandom_range(0, 3) != 0);
        vin_x = cx; vin_y = cy; vin_z = cz;
        flush     = ($urandom_range(0, 15) == 0);
        mtx_ready = ($urandom_range(0, 1) == 1);
        @(negedge clk);
        m_data = '0;
        for (int k = 0; k < 4; k++)
          if (m_mask[k]) m_data[255-64*k -: 64] = col(mx[k], my[k], mz[k]);
        chk("rand_cycle",
            300'({vin_ready, mtx_valid, batch_cnt, m_hold ? mtx_mask : 4'h0,
                  m_hold ? mtx_data : 256'h0}),
            300'({!m_hold, m_hold, m_bc, m_hold ? m_mask : 4'h0, m_hold ? m_data : 256'h0}));
        if (!m_hold) begin
          if (vin_valid) begin
            mx[m_cnt] = cx; my[m_cnt] = cy; mz[m_cnt] = cz;
            m_cnt++;
            accepted++;
            have = 1'b0;
          end
          if (m_cnt == 4) begin
            m_hold = 1'b1; m_mask = 4'hF;
          end else if (flush && m_cnt > 0) begin
            m_hold = 1'b1; m_mask = 4'((1 << m_cnt) - 1);
          end
        end else if (mtx_ready) begin
          m_hold = 1'b0; m_mask = '0; m_cnt = 0; m_bc++;
          for (int k = 0; k < 4; k++) begin mx[k] = '0; my[k] = '0; mz[k] = '0; end
        end
        @(posedge clk);
        #1;
        cyc++;
      end
      chk("rand_budget", 300'(accepted >= 10000), 300'(1));
    end

    // batch counter wrap
    step(0,0,16'h0,16'h0,16'h0,0,0);
    force dut.batch_cnt_q = 16'hFFFF;
    step(1,0,16'h0,16'h0,16'h0,0,0);
    release dut.batch_cnt_q;
    step(1,0,16'h0,16'h0,16'h0,0,0);
    chk("wrap_preset", 300'(batch_cnt), 300'(16'hFFFF));
    step(1,1,16'h0001,16'h0001,16'h0001,0,0);
    step(1,1,16'h0002,16'h0002,16'h0002,0,0);
    step(1,1,16'h0003,16'h0003,16'h0003,0,0);
    step(1,1,16'h0004,16'h0004,16'h0004,0,0);
    chk("wrap_hold", 300'({mtx_valid, batch_cnt}), 300'({1'b1, 16'hFFFF}));
    step(1,0,16'h0,16'h0,16'h0,0,1);
    chk("wrap_zero", 300'({vin_ready, mtx_valid, batch_cnt}), 300'({1'b1, 1'b0, 16'h0000}));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
